// File: rtl/sel_pipe.sv
// sel_pipe: registered NUM_IN-way selector with valid/ready handshake and a
// two-entry skid buffer; out-of-range selects yield zero, are flagged and counted.
`default_nettype none

module sel_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   main_q;
  logic [WIDTH:0]   skid_q;
  logic [WIDTH-1:0] pick_data;
  logic             pick_err;
  logic             accept;
  logic             drain;

  always_comb begin
    pick_data = '0;
    pick_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(in_sel) == k) begin
        pick_data = in_data[k*WIDTH +: WIDTH];
        pick_err  = 1'b0;
      end
    end
  end

  // Handshake flags come straight from registered state, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q[WIDTH-1:0];
  assign out_err   = main_q[WIDTH];
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      err_count <= '0;
    end else begin
      if (accept && pick_err && !flush && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              main_q <= {pick_err, pick_data};
              state  <= ONE;
            end
          end
          ONE: begin
            if (accept && drain) begin
              main_q <= {pick_err, pick_data};
            end else if (accept) begin
              skid_q <= {pick_err, pick_data};
              state  <= TWO;
            end else if (drain) begin
              state  <= EMPTY;
            end
          end
          TWO: begin
            if (drain) begin
              main_q <= skid_q;
              state  <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sel_pipe.sv
// tb_sel_pipe: directed vector table plus corner-case sequences for sel_pipe,
// and a reference-queue check on a WIDTH=32/NUM_IN=4 instance.
`default_nettype none

module tb_sel_pipe;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        flush;
  logic [14:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_data;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_count;

  logic         w_flush;
  logic [127:0] w_in_data;
  logic [1:0]   w_in_sel;
  logic         w_in_valid;
  logic         w_in_ready;
  logic [31:0]  w_out_data;
  logic         w_out_err;
  logic         w_out_valid;
  logic         w_out_ready;
  logic [7:0]   w_err_count;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sel_pipe dut (
    .CLK(CLK), .Reset(Reset), .flush(flush), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
  );

  sel_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut_w (
    .CLK(CLK), .Reset(Reset), .flush(w_flush), .in_data(w_in_data), .in_sel(w_in_sel),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .out_data(w_out_data), .out_err(w_out_err),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .err_count(w_err_count)
  );

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic       ordy;
    logic       fl;
    logic       e_ov;
    logic [4:0] e_data;
    logic       e_err;
    logic       e_ir;
    logic [7:0] e_cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic ordy, input logic fl);
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
    flush     = fl;
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[19];

  initial begin
    logic [31:0] cand[4];
    logic [31:0] q[$];
    logic [31:0] exp_w;
    logic        acc;
    logic        drn;
    logic [1:0]  s;

    // candidates C=9, B=3, A=17
    in_data = {5'd9, 5'd3, 5'd17};
    vecs = '{
      '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 5'd17, 1'b0, 1'b1, 8'd0},  // stream
      '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 1'b1, 8'd0},
      '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 8'd0},
      '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 8'd0},
      '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b1, 8'd0},  // back-pressure
      '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b0, 8'd0},
      '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b0, 8'd0},
      '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 1'b1, 8'd0},
      '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 8'd0},
      '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 8'd0},
      '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 5'd0,  1'b1, 1'b1, 8'd1},  // out of range
      '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 8'd1},
      '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b1, 8'd1},  // flush from TWO
      '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b0, 8'd2},
      '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 8'd2},
      '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 8'd2},
      '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b1, 8'd2},  // flush kills accept
      '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 8'd2},
      '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 8'd2}
    };

    Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = '0; out_ready = 1'b0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_in_sel = '0; w_out_ready = 1'b0; w_in_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err_count", err_count, 0);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].sel, vecs[i].ordy, vecs[i].fl);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) begin
        check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_data);
        check($sformatf("vec%0d_out_err", i), out_err, vecs[i].e_err);
      end
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("vec%0d_err_count", i), err_count, vecs[i].e_cnt);
    end

    // 300 out-of-range beats on top of the 2 already counted
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 2'd3, 1'b1, 1'b0);
      if (i == 100) check("sat_mid_count", err_count, 8'd103);
    end
    check("sat_count", err_count, 8'd255);
    check("sat_out_err", out_err, 1);
    check("sat_out_data", out_data, 0);

    // reset while holding two beats
    step(1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    check("pre_rst_in_ready", in_ready, 0);
    Reset = 1'b1;
    step(1'b1, 2'd2, 1'b1, 1'b0);
    Reset = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_err", out_err, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_err_count", err_count, 0);
    step(1'b1, 2'd1, 1'b1, 1'b0);
    check("postrst_out_valid", out_valid, 1);
    check("postrst_out_data", out_data, 3);
    step(1'b0, 2'd0, 1'b1, 1'b0);

    // wide instance: select of the last candidate is legal
    cand[0] = 32'h1111_0000; cand[1] = 32'h2222_0001;
    cand[2] = 32'h3333_0002; cand[3] = 32'hDEAD_BEEF;
    w_in_data   = {cand[3], cand[2], cand[1], cand[0]};
    w_in_valid  = 1'b1; w_in_sel = 2'd3; w_out_ready = 1'b1;
    @(posedge CLK); #1;
    w_in_valid = 1'b0;
    check("w_sel3_valid", w_out_valid, 1);
    check("w_sel3_data", w_out_data, 32'hDEAD_BEEF);
    check("w_sel3_err", w_out_err, 0);
    @(posedge CLK); #1;

    // random valid/ready against a reference queue
    for (int c = 0; c < 3000; c++) begin
      if (c < 2500) begin
        w_in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        w_in_valid = 1'b0;
      end
      w_out_ready = ($urandom_range(0, 2) != 0) || (c >= 2500);
      for (int k = 0; k < 4; k++) cand[k] = $urandom;
      w_in_data = {cand[3], cand[2], cand[1], cand[0]};
      s = 2'($urandom_range(0, 3));
      w_in_sel = s;
      acc = w_in_valid && w_in_ready;
      drn = w_out_valid && w_out_ready;
      if (drn) begin
        if (q.size() == 0) begin
          check("w_rand_spurious_beat", 1, 0);
        end else begin
          exp_w = q.pop_front();
          check("w_rand_data", w_out_data, exp_w);
        end
      end
      if (acc) q.push_back(cand[s]);
      @(posedge CLK); #1;
    end
    check("w_rand_queue_empty", q.size(), 0);
    check("w_rand_out_valid_end", w_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
